// File: rtl/gpu_pa_pkg.sv
// Shared types for the primitive assembler: topology, FSM state, and
// vertex-width helper.
package gpu_pa_pkg;

  typedef enum logic [1:0] {
    TOPO_LIST  = 2'd0,
    TOPO_STRIP = 2'd1,
    TOPO_FAN   = 2'd2
  } topology_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } pa_state_t;

  function automatic int calc_vw(input int aw, input int apv);
    return aw * apv;
  endfunction

endpackage

// File: rtl/pa_tri_fifo.sv
// Show-ahead triangle FIFO between the assembler and rasterizer setup.
// Output data reads as zero while the FIFO is empty.
module pa_tri_fifo
  import gpu_pa_pkg::*;
#(
  parameter int W     = 768,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/primitive_assembler.sv
// Groups fetched vertices into list/strip/fan triangles and queues them.
// Optional degenerate-triangle culling: define PA_DEGENERATE_CULL_EN.
module primitive_assembler
  import gpu_pa_pkg::*;
#(
  parameter int ATTR_WIDTH       = 32,
  parameter int ATTRS_PER_VERTEX = 8,
  parameter int FIFO_DEPTH       = 4,
  localparam int VW = calc_vw(ATTR_WIDTH, ATTRS_PER_VERTEX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_draw_start,
  input  logic [1:0]    i_topology,
  input  logic [15:0]   i_vertex_count,
  input  logic          i_vtx_valid,
  input  logic [VW-1:0] i_vtx_data,
  output logic          o_vtx_ready,
  output logic          o_tri_valid,
  output logic [3*VW-1:0] o_tri_data,
  input  logic          i_tri_ready,
  output logic          o_busy,
  output logic          o_draw_done
);

  pa_state_t state;
  topology_t topo;
  logic [15:0] count;
  logic [15:0] acc;
  logic [1:0]  slot;
  logic        k_odd;
  logic [VW-1:0] va;
  logic [VW-1:0] vb;

  logic accept;
  logic emit;
  logic push;
  logic full;
  logic empty;
  logic [3*VW-1:0] tri_d;

  assign o_vtx_ready = (state == COLLECT) &&
                       (acc < count) && !full;
  assign accept = i_vtx_valid && o_vtx_ready;
  assign o_tri_valid = !empty;

  always_comb begin
    emit  = 1'b0;
    tri_d = {i_vtx_data, vb, va};
    unique case (1'b1)
      (topo == TOPO_STRIP): begin
        emit = (acc >= 16'd2);
        // odd strip triangles swap v0/v1 to keep winding
        if (k_odd)
          tri_d = {i_vtx_data, va, vb};
      end
      (topo == TOPO_FAN): emit = (acc >= 16'd2);
      default: emit = (slot == 2'd2);
    endcase
  end

`ifdef PA_DEGENERATE_CULL_EN
  localparam int PW = 3 * ATTR_WIDTH;
  logic [PW-1:0] p0;
  logic [PW-1:0] p1;
  logic [PW-1:0] p2;
  logic degen;
  assign p0 = tri_d[PW-1:0];
  assign p1 = tri_d[VW+PW-1:VW];
  assign p2 = tri_d[2*VW+PW-1:2*VW];
  assign degen = (p0 == p1) || (p1 == p2) ||
                 (p0 == p2);
  assign push = accept && emit && !degen;
`else
  assign push = accept && emit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      topo        <= TOPO_LIST;
      count       <= '0;
      acc         <= '0;
      slot        <= '0;
      k_odd       <= 1'b0;
      va          <= '0;
      vb          <= '0;
      o_busy      <= 1'b0;
      o_draw_done <= 1'b0;
    end else begin
      o_draw_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_draw_start) begin
            topo  <= (i_topology == 2'd3) ? TOPO_LIST
                     : topology_t'(i_topology);
            count  <= i_vertex_count;
            acc    <= '0;
            slot   <= '0;
            k_odd  <= 1'b0;
            o_busy <= 1'b1;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (acc == count)
            state <= DRAIN;
          if (accept) begin
            acc <= acc + 16'd1;
            unique case (1'b1)
              (topo == TOPO_STRIP): begin
                if (acc == 16'd0)
                  va <= i_vtx_data;
                else if (acc == 16'd1)
                  vb <= i_vtx_data;
                else begin
                  va    <= vb;
                  vb    <= i_vtx_data;
                  k_odd <= ~k_odd;
                end
              end
              (topo == TOPO_FAN): begin
                if (acc == 16'd0)
                  va <= i_vtx_data;
                else
                  vb <= i_vtx_data;
              end
              default: begin
                if (slot == 2'd0)
                  va <= i_vtx_data;
                if (slot == 2'd1)
                  vb <= i_vtx_data;
                slot <= (slot == 2'd2) ? 2'd0
                        : slot + 2'd1;
              end
            endcase
          end
        end
        DRAIN: begin
          if (empty) begin
            state       <= DONE;
            o_draw_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pa_tri_fifo #(
    .W     (3 * VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (tri_d),
    .pop   (i_tri_ready),
    .rdata (o_tri_data),
    .full  (full),
    .empty (empty)
  );

endmodule
